// File: rtl/tx_scheduler_if.sv
// Request/handshake bundle between the protocol layer, the tx block and tx_scheduler.
// The pkt_count/err_count statistics exist only when TX_SCHED_STATS_EN is defined.
interface tx_scheduler_if;
   logic        hs_req;
   logic [1:0]  hs_type;
   logic        data_req;
   logic        clear_toggle;
   logic        tx_transfer_active;
   logic        tx_error;
   logic [2:0]  tx_packet;
   logic        hs_done;
   logic        data_done;
   logic        done_err;
   logic        data_toggle;
   logic        busy;
`ifdef TX_SCHED_STATS_EN
   logic [15:0] pkt_count;
   logic [7:0]  err_count;
`endif

   modport master (
      output hs_req, hs_type, data_req, clear_toggle, tx_transfer_active, tx_error,
      input  tx_packet, hs_done, data_done, done_err, data_toggle, busy
`ifdef TX_SCHED_STATS_EN
      , input pkt_count, err_count
`endif
   );

   modport slave (
      input  hs_req, hs_type, data_req, clear_toggle, tx_transfer_active, tx_error,
      output tx_packet, hs_done, data_done, done_err, data_toggle, busy
`ifdef TX_SCHED_STATS_EN
      , output pkt_count, err_count
`endif
   );
endinterface

// File: rtl/tx_scheduler.sv
// USB transmit scheduler: arbitrates handshake vs data packets, tracks each packet on the
// tx block, enforces the inter-packet gap and owns the DATA0/DATA1 toggle (stats: TX_SCHED_STATS_EN).
module tx_scheduler #(
   parameter int IPG_CYCLES    = 16,
   parameter int START_TIMEOUT = 64
) (
   input logic           clk,
   input logic           rst,
   tx_scheduler_if.slave bus
);

   localparam logic [2:0] PKT_IDLE  = 3'd0;
   localparam logic [2:0] PKT_DATA0 = 3'd1;
   localparam logic [2:0] PKT_DATA1 = 3'd2;
   localparam logic [2:0] PKT_ACK   = 3'd3;
   localparam logic [2:0] PKT_NAK   = 3'd4;
   localparam logic [2:0] PKT_STALL = 3'd5;

   localparam int WAIT_W = $clog2(START_TIMEOUT + 1);
   localparam int GAP_W  = $clog2(IPG_CYCLES + 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(START_TIMEOUT - 1);
   localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(IPG_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_ISSUE      = 3'd1,
      S_WAIT_START = 3'd2,
      S_ACTIVE     = 3'd3,
      S_GAP        = 3'd4
   } state_t;

   state_t            state;
   logic [WAIT_W-1:0] wait_cnt;
   logic [GAP_W-1:0]  gap_cnt;
   logic              is_data;
   logic              err_cap;
   logic              toggle;
   logic [2:0]        hs_code;
   logic              finish;
   logic              finish_err;

   assign bus.data_toggle = toggle;

   always_comb begin
      hs_code = PKT_NAK;
      case (bus.hs_type)
         2'd0:    hs_code = PKT_ACK;
         2'd2:    hs_code = PKT_STALL;
         default: hs_code = PKT_NAK;
      endcase
   end

   // wait_cnt counts clocks since the issue cycle, so the timeout lands START_TIMEOUT clocks after it
   always_comb begin
      finish     = 1'b0;
      finish_err = 1'b0;
      case (state)
         S_WAIT_START: begin
            if (!bus.tx_transfer_active && wait_cnt == WAIT_LAST) begin
               finish     = 1'b1;
               finish_err = 1'b1;
            end
         end
         S_ACTIVE: begin
            if (!bus.tx_transfer_active) begin
               finish     = 1'b1;
               finish_err = err_cap | bus.tx_error;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_IDLE;
         wait_cnt      <= '0;
         gap_cnt       <= '0;
         is_data       <= 1'b0;
         err_cap       <= 1'b0;
         toggle        <= 1'b0;
         bus.tx_packet <= PKT_IDLE;
         bus.hs_done   <= 1'b0;
         bus.data_done <= 1'b0;
         bus.done_err  <= 1'b0;
         bus.busy      <= 1'b0;
`ifdef TX_SCHED_STATS_EN
         bus.pkt_count <= '0;
         bus.err_count <= '0;
`endif
      end else begin
         bus.tx_packet <= PKT_IDLE;
         bus.hs_done   <= 1'b0;
         bus.data_done <= 1'b0;
         bus.done_err  <= 1'b0;

         if (finish) begin
            bus.hs_done   <= ~is_data;
            bus.data_done <= is_data;
            bus.done_err  <= finish_err;
`ifdef TX_SCHED_STATS_EN
            if (bus.pkt_count != '1)
               bus.pkt_count <= bus.pkt_count + 16'd1;
            if (finish_err && bus.err_count != '1)
               bus.err_count <= bus.err_count + 8'd1;
`endif
         end

         // A SETUP-driven clear beats a flip landing on the same edge
         if (bus.clear_toggle)
            toggle <= 1'b0;
         else if (finish && is_data && !finish_err)
            toggle <= ~toggle;

         case (state)
            S_IDLE: begin
               if (bus.hs_req) begin
                  is_data       <= 1'b0;
                  bus.tx_packet <= hs_code;
                  bus.busy      <= 1'b1;
                  state         <= S_ISSUE;
               end else if (bus.data_req) begin
                  is_data       <= 1'b1;
                  bus.tx_packet <= toggle ? PKT_DATA1 : PKT_DATA0;
                  bus.busy      <= 1'b1;
                  state         <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               wait_cnt <= WAIT_W'(1);
               state    <= S_WAIT_START;
            end
            S_WAIT_START: begin
               if (bus.tx_transfer_active) begin
                  err_cap <= 1'b0;
                  state   <= S_ACTIVE;
               end else if (finish) begin
                  gap_cnt <= '0;
                  state   <= S_GAP;
               end else begin
                  wait_cnt <= wait_cnt + WAIT_W'(1);
               end
            end
            S_ACTIVE: begin
               if (bus.tx_error)
                  err_cap <= 1'b1;
               if (finish) begin
                  gap_cnt <= '0;
                  state   <= S_GAP;
               end
            end
            S_GAP: begin
               if (gap_cnt == GAP_LAST) begin
                  bus.busy <= 1'b0;
                  state    <= S_IDLE;
               end else begin
                  gap_cnt <= gap_cnt + GAP_W'(1);
               end
            end
            default: begin
               bus.busy <= 1'b0;
               state    <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tx_scheduler.sv
// Self-checking bench for tx_scheduler: directed test-plan steps plus randomized packets,
// checked cycle by cycle against a transaction-level model of packet timing and the toggle.
module tb_tx_scheduler;

   localparam int IPG = 16;
   localparam int TO  = 64;

   logic clk;
   logic rst;
   int   total;
   int   bad;
   bit   model_toggle;
   int   model_pkt;
   int   model_err;
   logic [2:0] hs_pid [4] = '{3'd3, 3'd4, 3'd5, 3'd4};

   tx_scheduler_if bus();

   tx_scheduler #(.IPG_CYCLES(IPG), .START_TIMEOUT(TO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog obs=still_running exp=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic [7:0] mk(input logic [2:0] p, input bit hd, input bit dd,
                                     input bit er, input bit bz, input bit tg);
      return {p, hd, dd, er, bz, tg};
   endfunction

   // Observed vector is {tx_packet, hs_done, data_done, done_err, busy, data_toggle}
   task automatic checkOutput(input logic [7:0] exp, input string tag);
      logic [7:0] obs;
      obs = {bus.tx_packet, bus.hs_done, bus.data_done, bus.done_err, bus.busy, bus.data_toggle};
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s obs=%b exp=%b", tag, obs, exp);
      end
   endtask

   // One packet from an idle scheduler; rise_d==0 means tx never starts (timeout)
   task automatic applyStimulus(input bit do_hs, input bit do_data, input logic [1:0] ht,
                                input int rise_d, input int act_len, input int err_at,
                                input bit clr_mid, input bit clr_at_done, input string tag);
      logic [2:0] code;
      bit         failed;
      int         n_wait;
      code = do_hs ? hs_pid[ht] : (model_toggle ? 3'd2 : 3'd1);
      bus.hs_type = ht;
      if (do_hs)   bus.hs_req   = 1'b1;
      if (do_data) bus.data_req = 1'b1;
      tick();
      checkOutput(mk(code, 0, 0, 0, 1, model_toggle), {tag, "/issue"});
      if ($urandom_range(1, 0) == 1) begin
         if (do_hs) bus.hs_req = 1'b0; else bus.data_req = 1'b0;
      end

      n_wait = (rise_d == 0) ? TO - 1 : rise_d;
      for (int i = 1; i <= n_wait; i++) begin
         bus.clear_toggle = clr_mid && (i == 1);
         bus.tx_error     = 1'($urandom_range(1, 0));
         tick();
         if (clr_mid && i == 1) model_toggle = 1'b0;
         checkOutput(mk(0, 0, 0, 0, 1, model_toggle), $sformatf("%s/wait%0d", tag, i));
      end
      bus.clear_toggle = 1'b0;
      bus.tx_error     = 1'b0;

      if (rise_d == 0) begin
         failed = 1'b1;
      end else begin
         failed = 1'b0;
         bus.tx_transfer_active = 1'b1;
         for (int j = 1; j <= act_len; j++) begin
            bus.tx_error = (j == err_at);
            tick();
            if (j == err_at) failed = 1'b1;
            checkOutput(mk(0, 0, 0, 0, 1, model_toggle), $sformatf("%s/act%0d", tag, j));
         end
         bus.tx_transfer_active = 1'b0;
         bus.tx_error           = 1'b0;
      end
      bus.clear_toggle = clr_at_done;
      tick();
      if (clr_at_done) model_toggle = 1'b0;
      else if (!do_hs && !failed) model_toggle = ~model_toggle;
      model_pkt++;
      if (failed) model_err++;
      checkOutput(mk(0, do_hs, !do_hs, failed, 1, model_toggle), {tag, "/done"});
      bus.clear_toggle = 1'b0;
      if (do_hs) bus.hs_req = 1'b0; else bus.data_req = 1'b0;

      // Spurious tx activity inside the gap must be ignored
      for (int k = 1; k < IPG; k++) begin
         bus.tx_transfer_active = 1'($urandom_range(1, 0));
         bus.tx_error           = 1'($urandom_range(1, 0));
         tick();
         checkOutput(mk(0, 0, 0, 0, 1, model_toggle), $sformatf("%s/gap%0d", tag, k));
      end
      bus.tx_transfer_active = 1'b0;
      bus.tx_error           = 1'b0;
      tick();
      checkOutput(mk(0, 0, 0, 0, 0, model_toggle), {tag, "/idle"});
   endtask

   task automatic checkStats(input string tag);
`ifdef TX_SCHED_STATS_EN
      total++;
      assert (bus.pkt_count === 16'(model_pkt)) else begin
         bad++;
         $error("[TB] FAIL %s_pkt obs=%0d exp=%0d", tag, bus.pkt_count, model_pkt);
      end
      total++;
      assert (bus.err_count === 8'(model_err)) else begin
         bad++;
         $error("[TB] FAIL %s_err obs=%0d exp=%0d", tag, bus.err_count, model_err);
      end
`else
      if (tag.len() == 0) $display("[TB] stats disabled");
`endif
   endtask

   bit         r_hs;
   bit         r_data;
   logic [1:0] r_type;
   int         r_rise;
   int         r_len;
   int         r_err;

   initial begin
      total = 0;
      bad   = 0;
      model_toggle = 1'b0;
      model_pkt = 0;
      model_err = 0;
      rst = 1'b1;
      bus.hs_req = 1'b0;
      bus.hs_type = 2'd0;
      bus.data_req = 1'b0;
      bus.clear_toggle = 1'b0;
      bus.tx_transfer_active = 1'b0;
      bus.tx_error = 1'b0;
      tick();
      tick();
      checkOutput(mk(0, 0, 0, 0, 0, 0), "reset");
      checkStats("reset_stats");
      rst = 1'b0;
      tick();
      checkOutput(mk(0, 0, 0, 0, 0, 0), "post_reset");

      applyStimulus(0, 1, 2'd0, 3, 20, 0, 0, 0, "t1_data0");
      applyStimulus(1, 1, 2'd2, 2, 5, 0, 0, 0, "t2_stall");
      applyStimulus(0, 1, 2'd0, 4, 6, 0, 0, 0, "t2_data1");
      applyStimulus(0, 1, 2'd0, 0, 0, 0, 0, 0, "t3_timeout");
      applyStimulus(0, 1, 2'd0, 2, 10, 5, 0, 0, "t4_err");
      applyStimulus(0, 1, 2'd0, 1, 4, 0, 0, 0, "t4_next");
      applyStimulus(1, 0, 2'd1, 2, 3, 0, 1, 0, "t5_clr_mid");
      applyStimulus(0, 1, 2'd0, 2, 8, 0, 0, 1, "t5_clr_done");
      applyStimulus(1, 0, 2'd3, 1, 2, 0, 0, 0, "t6_reserved");
      applyStimulus(1, 0, 2'd0, 5, 7, 0, 0, 0, "t6_ack");

      for (int n = 0; n < 14; n++) begin
         r_hs   = 1'($urandom_range(1, 0));
         r_data = r_hs ? 1'($urandom_range(1, 0)) : 1'b1;
         r_type = 2'($urandom_range(3, 0));
         r_rise = ($urandom_range(5, 0) == 0) ? 0 : int'($urandom_range(10, 1));
         r_len  = int'($urandom_range(25, 1));
         r_err  = (r_len >= 2 && $urandom_range(2, 0) == 0) ? int'($urandom_range(r_len, 2)) : 0;
         applyStimulus(r_hs, r_data, r_type, r_rise, r_len, r_err,
                       $urandom_range(3, 0) == 0, $urandom_range(3, 0) == 0,
                       $sformatf("rnd%0d", n));
         bus.data_req = 1'b0;
      end

      if (!model_toggle)
         applyStimulus(0, 1, 2'd0, 2, 3, 0, 0, 0, "t7_prep");
      bus.data_req = 1'b1;
      tick();
      checkOutput(mk(model_toggle ? 3'd2 : 3'd1, 0, 0, 0, 1, model_toggle), "t7_issue");
      bus.data_req = 1'b0;
      bus.tx_transfer_active = 1'b1;
      tick();
      tick();
      tick();
      rst = 1'b1;
      tick();
      model_toggle = 1'b0;
      model_pkt = 0;
      model_err = 0;
      checkOutput(mk(0, 0, 0, 0, 0, 0), "t7_rst_active");
      checkStats("t7_rst_stats");
      rst = 1'b0;
      bus.tx_transfer_active = 1'b0;
      tick();
      checkOutput(mk(0, 0, 0, 0, 0, 0), "t7_idle");

      applyStimulus(0, 1, 2'd0, 2, 4, 0, 0, 0, "s_good1");
      applyStimulus(1, 0, 2'd0, 3, 2, 0, 0, 0, "s_good2");
      applyStimulus(0, 1, 2'd0, 1, 6, 0, 0, 0, "s_good3");
      applyStimulus(0, 1, 2'd0, 0, 0, 0, 0, 0, "s_timeout");
      checkStats("stats");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
